// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - memory bus responder: IM/DM RAMs, host load/dump port, run control
module memory_responder #(
   parameter int          IM_AW     = 8,
   parameter int          DM_AW     = 12,
   parameter logic [15:0] DONE_ADDR = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic        dm_wr,
   input  logic        im_wr,
   input  logic [15:0] to_mem,
   output logic [7:0]  dm_out,
   output logic [7:0]  im_out,
   output logic        proc_en,
   input  logic        run,
   output logic        done,
   input  logic        h_valid,
   output logic        h_ready,
   input  logic [1:0]  h_cmd,
   input  logic [15:0] h_addr,
   input  logic [7:0]  h_wdata,
   output logic        r_valid,
   output logic [7:0]  r_data,
   output logic [31:0] run_cycles
);
   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DUMP = 2'd2;

   localparam logic [1:0] CMD_WR_IM = 2'b00;
   localparam logic [1:0] CMD_WR_DM = 2'b01;
   localparam logic [1:0] CMD_RD_DM = 2'b10;

   logic [7:0] im_mem [0:(1 << IM_AW) - 1];
   logic [7:0] dm_mem [0:(1 << DM_AW) - 1];

   logic [1:0]  state_q, state_d;
   logic [31:0] run_cycles_q, run_cycles_d;
   logic [7:0]  dm_out_q, dm_out_d;
   logic [7:0]  im_out_q, im_out_d;
   logic [7:0]  r_data_q, r_data_d;
   logic        r_valid_q, r_valid_d;

   logic             in_run;
   logic             host_xfer;
   logic             done_store;
   logic [IM_AW-1:0] p_im_addr, h_im_addr, im_waddr;
   logic [DM_AW-1:0] p_dm_addr, h_dm_addr, dm_waddr;
   logic             im_we, dm_we;
   logic [7:0]       im_wdata, dm_wdata;
   logic             unused_bits;

   assign p_im_addr = addr[IM_AW-1:0];
   assign p_dm_addr = addr[DM_AW-1:0];
   assign h_im_addr = h_addr[IM_AW-1:0];
   assign h_dm_addr = h_addr[DM_AW-1:0];
   assign unused_bits = ^{h_addr[15:DM_AW], to_mem[15:8]};

   assign in_run     = (state_q == ST_RUN);
   assign proc_en    = in_run;
   assign done       = (state_q == ST_DUMP);
   assign h_ready    = !in_run;
   assign host_xfer  = h_valid && h_ready;
   assign done_store = in_run && dm_wr && (addr == DONE_ADDR);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD, ST_DUMP: if (run) state_d = ST_RUN;
         ST_RUN:           if (done_store) state_d = ST_DUMP;
         default:          state_d = ST_LOAD;
      endcase
   end

   // A single write port per RAM, muxed between processor (RUN) and host (LOAD/DUMP).
   always_comb begin
      im_we    = 1'b0;
      dm_we    = 1'b0;
      im_waddr = p_im_addr;
      dm_waddr = p_dm_addr;
      im_wdata = to_mem[7:0];
      dm_wdata = to_mem[7:0];
      if (in_run) begin
         im_we = im_wr;
         dm_we = dm_wr && !done_store;
      end else if (host_xfer) begin
         im_waddr = h_im_addr;
         dm_waddr = h_dm_addr;
         im_wdata = h_wdata;
         dm_wdata = h_wdata;
         im_we    = (h_cmd == CMD_WR_IM);
         dm_we    = (h_cmd == CMD_WR_DM);
      end
   end

   always_ff @(posedge clk) begin
      if (im_we) im_mem[im_waddr] <= im_wdata;
      if (dm_we) dm_mem[dm_waddr] <= dm_wdata;
   end

   // Reads sample the array before this edge's write lands, giving read-first behaviour.
   always_comb begin
      dm_out_d = dm_out_q;
      im_out_d = im_out_q;
      if (in_run) begin
         dm_out_d = dm_mem[p_dm_addr];
         im_out_d = im_mem[p_im_addr];
      end
      r_valid_d = host_xfer && h_cmd[1];
      r_data_d  = r_data_q;
      if (r_valid_d) begin
         r_data_d = (h_cmd == CMD_RD_DM) ? dm_mem[h_dm_addr] : im_mem[h_im_addr];
      end
      run_cycles_d = run_cycles_q;
      if (!in_run && state_d == ST_RUN) begin
         run_cycles_d = '0;
      end else if (in_run && run_cycles_q != 32'hFFFF_FFFF) begin
         run_cycles_d = run_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_LOAD;
         run_cycles_q <= '0;
         dm_out_q     <= '0;
         im_out_q     <= '0;
         r_data_q     <= '0;
         r_valid_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_cycles_q <= run_cycles_d;
         dm_out_q     <= dm_out_d;
         im_out_q     <= im_out_d;
         r_data_q     <= r_data_d;
         r_valid_q    <= r_valid_d;
      end
   end

   assign dm_out     = dm_out_q;
   assign im_out     = im_out_q;
   assign r_data     = r_data_q;
   assign r_valid    = r_valid_q;
   assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - randomized self-checking bench for memory_responder
module tb_memory_responder;
   localparam int IM_D = 256;
   localparam int DM_D = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] addr = '0;
   logic        dm_wr = 1'b0;
   logic        im_wr = 1'b0;
   logic [15:0] to_mem = '0;
   logic [7:0]  dm_out, im_out;
   logic        proc_en;
   logic        run = 1'b0;
   logic        done;
   logic        h_valid = 1'b0;
   logic        h_ready;
   logic [1:0]  h_cmd = '0;
   logic [15:0] h_addr = '0;
   logic [7:0]  h_wdata = '0;
   logic        r_valid;
   logic [7:0]  r_data;
   logic [31:0] run_cycles;

   always #5 clk = ~clk;

   memory_responder #(.IM_AW(8), .DM_AW(12), .DONE_ADDR(16'hFFFF)) dut (
      .clk(clk), .rst(rst), .addr(addr), .dm_wr(dm_wr), .im_wr(im_wr),
      .to_mem(to_mem), .dm_out(dm_out), .im_out(im_out), .proc_en(proc_en),
      .run(run), .done(done), .h_valid(h_valid), .h_ready(h_ready),
      .h_cmd(h_cmd), .h_addr(h_addr), .h_wdata(h_wdata), .r_valid(r_valid),
      .r_data(r_data), .run_cycles(run_cycles)
   );

   typedef enum int {M_LOAD, M_RUN, M_DUMP} mode_t;
   mode_t       m_mode = M_LOAD;
   logic [7:0]  m_im [IM_D];
   logic [7:0]  m_dm [DM_D];
   logic [31:0] m_cycles = '0;
   logic        m_rv = 1'b0;
   logic [7:0]  m_rd = '0, m_dmo = '0, m_imo = '0;

   // Behavioural reference: who owns the memories decides what each edge does.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = M_LOAD; m_cycles = '0; m_rv = 1'b0;
         m_rd = '0; m_dmo = '0; m_imo = '0;
      end else if (m_mode == M_RUN) begin
         m_dmo = m_dm[int'(addr) % DM_D];
         m_imo = m_im[int'(addr) % IM_D];
         m_rv  = 1'b0;
         if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
         if (im_wr) m_im[int'(addr) % IM_D] = to_mem[7:0];
         if (dm_wr && addr != 16'hFFFF) m_dm[int'(addr) % DM_D] = to_mem[7:0];
         if (dm_wr && addr == 16'hFFFF) m_mode = M_DUMP;
      end else begin
         m_rv = h_valid && (h_cmd == 2'b10 || h_cmd == 2'b11);
         if (m_rv) m_rd = (h_cmd == 2'b10) ? m_dm[int'(h_addr) % DM_D] : m_im[int'(h_addr) % IM_D];
         if (h_valid && h_cmd == 2'b00) m_im[int'(h_addr) % IM_D] = h_wdata;
         if (h_valid && h_cmd == 2'b01) m_dm[int'(h_addr) % DM_D] = h_wdata;
         if (run) begin m_mode = M_RUN; m_cycles = '0; end
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("proc_en", 32'(proc_en), 32'(m_mode == M_RUN));
      chk("done", 32'(done), 32'(m_mode == M_DUMP));
      chk("h_ready", 32'(h_ready), 32'(m_mode != M_RUN));
      chk("r_valid", 32'(r_valid), 32'(m_rv));
      chk("r_data", 32'(r_data), 32'(m_rd));
      chk("dm_out", 32'(dm_out), 32'(m_dmo));
      chk("im_out", 32'(im_out), 32'(m_imo));
      chk("run_cycles", run_cycles, m_cycles);
   endtask

   task automatic idle();
      addr = '0; dm_wr = 0; im_wr = 0; to_mem = '0; run = 0;
      h_valid = 0; h_cmd = '0; h_addr = '0; h_wdata = '0;
   endtask

   task automatic rand_host();
      h_valid = 1'($urandom_range(0, 1));
      h_cmd   = 2'($urandom);
      h_addr  = 16'($urandom);
      h_wdata = 8'($urandom);
   endtask

   task automatic host_read_expect(input logic [1:0] cmd, input logic [15:0] a,
                                   input logic [7:0] exp, input string name);
      @(negedge clk);
      idle(); h_valid = 1; h_cmd = cmd; h_addr = a;
      @(negedge clk);
      h_valid = 0;
      chk({name, "_r_valid"}, 32'(r_valid), 32'd1);
      chk(name, 32'(r_data), 32'(exp));
   endtask

   task automatic host_write(input logic [1:0] cmd, input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      idle(); h_valid = 1; h_cmd = cmd; h_addr = a; h_wdata = d;
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (!rst) compare_all();
         end
      join_none

      repeat (3) @(negedge clk);
      rst = 0;
      chk("reset_h_ready", 32'(h_ready), 32'd1);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_proc_en", 32'(proc_en), 32'd0);
      chk("reset_run_cycles", run_cycles, 32'd0);

      // Preload every location so the model knows all RAM contents.
      for (int i = 0; i < DM_D; i++) host_write(2'b01, 16'(i), 8'($urandom));
      for (int i = 0; i < IM_D; i++) host_write(2'b00, 16'(i), 8'($urandom));
      host_write(2'b01, 16'h0010, 8'h5A);
      host_write(2'b01, 16'h0FFF, 8'h3C);
      host_read_expect(2'b10, 16'h0010, 8'h5A, "host_rd_dm010");
      host_read_expect(2'b10, 16'h1010, 8'h5A, "host_rd_alias1010");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         idle(); h_valid = 1; h_cmd = 2'($urandom_range(2, 3)); h_addr = 16'($urandom);
      end

      @(negedge clk);
      idle(); run = 1;
      @(negedge clk);
      idle();
      chk("run_start_proc_en", 32'(proc_en), 32'd1);
      h_valid = 1; h_cmd = 2'b00; h_addr = 16'h0033; h_wdata = 8'hEE;
      dm_wr = 1; addr = 16'h0020; to_mem = 16'h12AB;
      @(negedge clk);
      dm_wr = 0; addr = 16'h0020;
      @(negedge clk);
      chk("proc_rd_dm_out", 32'(dm_out), 32'h00AB);
      chk("stall_h_ready", 32'(h_ready), 32'd0);
      dm_wr = 1; im_wr = 1; addr = 16'h0005; to_mem = 16'h0077;
      @(negedge clk);
      idle();
      @(negedge clk);
      idle(); dm_wr = 1; addr = 16'hFFFF; to_mem = 16'h0011;
      @(negedge clk);
      idle();
      chk("done_after_store", 32'(done), 32'd1);
      host_read_expect(2'b10, 16'h0FFF, 8'h3C, "done_dm_fff_kept");
      host_read_expect(2'b10, 16'h0020, 8'hAB, "proc_wr_dm020");
      host_read_expect(2'b10, 16'h0005, 8'h77, "dual_wr_dm");
      host_read_expect(2'b11, 16'h0005, 8'h77, "dual_wr_im");

      @(negedge clk);
      idle(); run = 1;
      @(negedge clk);
      idle();
      chk("restart_proc_en", 32'(proc_en), 32'd1);
      chk("restart_done", 32'(done), 32'd0);
      chk("restart_run_cycles", run_cycles, 32'd0);
      repeat (10) @(negedge clk);
      dm_wr = 1; addr = 16'hFFFF;
      @(negedge clk);
      idle();
      chk("ten_cycle_done", 32'(done), 32'd1);
      chk("ten_cycle_proc_en", 32'(proc_en), 32'd0);
      chk("ten_cycle_run_cycles", run_cycles, 32'd11);

      @(negedge clk);
      idle(); run = 1;
      @(negedge clk);
      idle();
      repeat (3) @(negedge clk);
      #2 rst = 1;
      #1 chk("rst_async_proc_en", 32'(proc_en), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      chk("post_rst_h_ready", 32'(h_ready), 32'd1);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_dm_out", 32'(dm_out), 32'd0);
      chk("post_rst_run_cycles", run_cycles, 32'd0);

      @(negedge clk);
      idle(); dm_wr = 1; im_wr = 1; addr = 16'h0005; to_mem = 16'h0099;
      host_read_expect(2'b10, 16'h0005, 8'h77, "load_strobe_ign_dm");
      host_read_expect(2'b11, 16'h0005, 8'h77, "load_strobe_ign_im");

      @(negedge clk);
      idle(); h_valid = 1; h_cmd = 2'b10; h_addr = 16'h0010;
      @(posedge clk);
      #1 rst = 1; h_valid = 0;
      #1 chk("rst_cancels_r_valid", 32'(r_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 0;

      @(negedge clk);
      idle(); h_valid = 1; h_cmd = 2'b01; h_addr = 16'h0040; h_wdata = 8'hC7; run = 1;
      @(negedge clk);
      idle();
      chk("run_with_cmd_proc_en", 32'(proc_en), 32'd1);
      dm_wr = 1; im_wr = 1; addr = 16'hFFFF; to_mem = 16'h005D;
      @(negedge clk);
      idle();
      host_read_expect(2'b10, 16'h0040, 8'hC7, "run_with_cmd_wr");
      host_read_expect(2'b11, 16'h00FF, 8'h5D, "done_with_im_wr");

      for (int it = 0; it < 8; it++) begin
         for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            idle(); rand_host();
            dm_wr = 1'($urandom_range(0, 1)); im_wr = 1'($urandom_range(0, 1));
            addr = 16'($urandom); to_mem = 16'($urandom);
         end
         @(negedge clk);
         idle(); rand_host(); run = 1;
         for (int c = 0; c < int'($urandom_range(10, 60)); c++) begin
            @(negedge clk);
            idle(); rand_host();
            case ($urandom_range(0, 7))
               0:       addr = 16'hFFFF;
               1:       addr = 16'($urandom);
               default: addr = 16'($urandom_range(0, 63));
            endcase
            dm_wr  = ($urandom_range(0, 3) == 0);
            im_wr  = ($urandom_range(0, 3) == 0);
            to_mem = 16'($urandom);
            run    = ($urandom_range(0, 15) == 0);
         end
         @(negedge clk);
         idle(); dm_wr = 1; addr = 16'hFFFF;
         @(negedge clk);
         idle();
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
